ptlrx_pulse_decoder: RTL and testbench

Clocked receive-side decoder for the transition-encoded PTL link. On this link every edge of the line, rising or falling, represents one SFQ pulse. The block synchronises the line and detects each transition. It forwards each transition as a one-cycle pulse and enforces the link's minimum pulse separation, flagging transitions that violate it. It sits at the far end of a PTL transmitter in mixed RSFQ/CMOS co-simulation and in FPGA emulation of RSFQ netlists.

---
 rtl/ptlrx_pulse_decoder.sv | 135 +++++++++++++
 tb/tb_ptlrx_pulse_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ptlrx_pulse_decoder.sv
// Receive-side decoder for a transition-encoded PTL line: synchronise, detect edges, enforce pulse separation.
// Optional pulse counter enabled by defining PTLRX_PULSE_CNT_EN; otherwise pulse_cnt is tied to 0.
module ptlrx_pulse_decoder #(
    parameter int BEGIN_CYCLES   = 8,
    parameter int MIN_GAP_CYCLES = 5,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             q,
    output logic             err,
    output logic             err_sticky,
    output logic             ready,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int BLANK_W = (BEGIN_CYCLES > 1) ? $clog2(BEGIN_CYCLES) : 1;
    localparam int GAP_W   = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BEGIN_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD   =
        GAP_W'((MIN_GAP_CYCLES > 1) ? (MIN_GAP_CYCLES - 2) : 0);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_HOLDOFF
    } state_t;

    logic               r_s1, r_s2, r_s3;
    logic               w_edge;
    state_t             r_state, w_state_nxt;
    logic [BLANK_W-1:0] r_blank_cnt, w_blank_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic               w_accept, w_reject;
    logic               r_q, r_err, r_sticky, r_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= a;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 ^ r_s3;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_blank_nxt = r_blank_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_blank_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_blank_nxt = r_blank_cnt - 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_edge) begin
                    w_accept = 1'b1;
                    if (MIN_GAP_CYCLES > 1) begin
                        w_state_nxt = ST_HOLDOFF;
                        w_gap_nxt   = GAP_LOAD;
                    end
                end
            end
            ST_HOLDOFF: begin
                // Rejected edges do not restart the gap: separation counts from the last accepted pulse.
                w_reject = w_edge;
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_blank_cnt <= BLANK_LOAD;
            r_gap_cnt   <= '0;
            r_q         <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_blank_cnt <= w_blank_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_q         <= w_accept;
            r_err       <= w_reject;
            r_ready     <= (w_state_nxt != ST_INIT);
            if (w_reject) begin
                r_sticky <= 1'b1;
            end
        end
    end

`ifdef PTLRX_PULSE_CNT_EN
    logic [CNT_W-1:0] r_pulse_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_cnt <= '0;
        end else if (w_accept && (r_pulse_cnt != '1)) begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
        end
    end

    assign pulse_cnt = r_pulse_cnt;
`else
    assign pulse_cnt = '0;
`endif

    assign q          = r_q;
    assign err        = r_err;
    assign err_sticky = r_sticky;
    assign ready      = r_ready;

endmodule

// File: tb/tb_ptlrx_pulse_decoder.sv
// Self-checking bench for ptlrx_pulse_decoder: timeline model of the decoding rules plus directed literal checks.
module tb_ptlrx_pulse_decoder;

    localparam int BEGIN_C = 8;
    localparam int GAP_C   = 5;
    localparam int CW      = 4;
`ifdef PTLRX_PULSE_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a   = 1'b0;
    logic          q, err, err_sticky, ready;
    logic [CW-1:0] pulse_cnt;

    ptlrx_pulse_decoder #(
        .BEGIN_CYCLES  (BEGIN_C),
        .MIN_GAP_CYCLES(GAP_C),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .q         (q),
        .err       (err),
        .err_sticky(err_sticky),
        .ready     (ready),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: smp[k] is the line level sampled at the k-th clock after reset release.
    // A transition between samples k-3 and k-2 is judged at clock k (three-clock latency).
    logic smp [0:8191];
    int   k = 0;
    int   last_acc = 0;
    bit   have_acc = 0;
    logic m_q = 0, m_err = 0, m_sticky = 0, m_ready = 0;
    int   m_cnt = 0;

    function automatic logic sample_at(input int idx);
        return (idx <= 0) ? 1'b0 : smp[idx];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k = 0; have_acc = 0; last_acc = 0;
            m_q = 0; m_err = 0; m_sticky = 0; m_ready = 0; m_cnt = 0;
        end else begin
            k++;
            m_q = 0;
            m_err = 0;
            if ((sample_at(k - 2) != sample_at(k - 3)) && (k > BEGIN_C)) begin
                if (!have_acc || (k - last_acc >= GAP_C)) begin
                    m_q = 1;
                    have_acc = 1;
                    last_acc = k;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end else begin
                    m_err = 1;
                    m_sticky = 1;
                end
            end
            m_ready = (k >= BEGIN_C);
            if (k < 8192) smp[k] = a;
        end
    end

    bit cmp_en = 0;
    int obs_q = 0, obs_err = 0;

    always @(negedge clk) begin
        if (q === 1'b1) obs_q++;
        if (err === 1'b1) obs_err++;
        if (cmp_en) begin
            check("cmp_q", q, m_q);
            check("cmp_err", err, m_err);
            check("cmp_sticky", err_sticky, m_sticky);
            check("cmp_ready", ready, m_ready);
            check("cmp_cnt", pulse_cnt, CNT_EN * m_cnt);
        end
    end

    // Called at a negedge in IDLE; pins the three-clock latency with literals.
    task automatic toggle_lat(input string nm);
        a = ~a;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_q_early"}, q, 0);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_q_on_time"}, q, 1);
    endtask

    initial begin
        int q0, e0;
        bit found;
        @(posedge clk);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        check("reset_q", q, 0);
        check("reset_ready", ready, 0);
        check("reset_cnt", pulse_cnt, 0);
        rst = 1'b0;

        // Blanking: ready after BEGIN_C clocks, toggles inside are ignored.
        for (int i = 1; i <= BEGIN_C; i++) begin
            if (i == 2 || i == 5) a = ~a;
            @(posedge clk);
            @(negedge clk);
            check("init_ready", ready, (i >= BEGIN_C) ? 1 : 0);
            check("init_q", q, 0);
            check("init_err", err, 0);
        end
        repeat (4) @(negedge clk);
        check("init_cnt", pulse_cnt, 0);

        // Two well-separated pulses.
        toggle_lat("pulse1");
        repeat (7) @(negedge clk);
        toggle_lat("pulse2");
        check("pulse2_cnt", pulse_cnt, 2 * CNT_EN);
        check("model_cnt2", m_cnt, 2);
        repeat (10) @(negedge clk);

        // Edges at t, t+2, t+5: reject t+2, accept t+5.
        @(posedge clk);
        q0 = obs_q; e0 = obs_err;
        @(negedge clk);
        a = ~a;
        repeat (2) @(negedge clk);
        a = ~a;
        repeat (3) @(negedge clk);
        a = ~a;
        repeat (10) @(negedge clk);
        @(posedge clk);
        check("gap_q_count", obs_q - q0, 2);
        check("gap_err_count", obs_err - e0, 1);
        @(negedge clk);
        check("gap_sticky", err_sticky, 1);
        check("gap_cnt", pulse_cnt, 4 * CNT_EN);

        // Edges at t, t+2, t+4, t+5: no holdoff restart.
        @(posedge clk);
        q0 = obs_q; e0 = obs_err;
        @(negedge clk);
        a = ~a;
        repeat (2) @(negedge clk);
        a = ~a;
        repeat (2) @(negedge clk);
        a = ~a;
        @(negedge clk);
        a = ~a;
        repeat (10) @(negedge clk);
        @(posedge clk);
        check("norestart_q_count", obs_q - q0, 2);
        check("norestart_err_count", obs_err - e0, 2);
        @(negedge clk);
        check("norestart_cnt", pulse_cnt, 6 * CNT_EN);

        // Fresh reset, then saturate the 4-bit counter with 20 accepted pulses.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_sticky", err_sticky, 0);
        rst = 1'b0;
        repeat (BEGIN_C + 1) @(negedge clk);
        a = ~a;
        repeat (2) @(negedge clk);
        a = ~a;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            a = ~a;
            repeat (8) @(negedge clk);
        end
        check("sat_cnt", pulse_cnt, 15 * CNT_EN);
        check("sat_sticky", err_sticky, 1);

        // Reset asserted mid-HOLDOFF with an err already in flight.
        a = ~a;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (q === 1'b1) found = 1;
        end
        check("holdoff_q_seen", found, 1);
        a = ~a;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_q", q, 0);
        check("abort_err", err, 0);
        check("abort_sticky", err_sticky, 0);
        check("abort_ready", ready, 0);
        check("abort_cnt", pulse_cnt, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("final_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
